// File: rtl/bidir_fifo_dir_arbiter.sv
// Direction controller for one side of the bidirectional async FIFO: owns dir/winc/rinc,
// negotiates write ownership with the peer. Define BIDIR_FIFO_ARB_STATS_EN for turn/word counters.
module bidir_fifo_dir_arbiter #(
    parameter int DSIZE         = 8,
    parameter bit MASTER        = 1'b1,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_BURST     = 16,
    parameter int IDLE_TIMEOUT  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    input  logic [DSIZE-1:0] tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [DSIZE-1:0] rx_data,
    input  logic             rx_ready,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_drained,
    output logic             fifo_dir,
    output logic             fifo_winc,
    output logic [DSIZE-1:0] fifo_wdata,
    output logic             fifo_rinc,
    output logic             own_req,
    input  logic             peer_req,
`ifdef BIDIR_FIFO_ARB_STATS_EN
    output logic [15:0]      stat_turns,
    output logic [31:0]      stat_tx_words,
`endif
    output logic             busy_tx
);

    typedef enum logic [1:0] {ST_RX, ST_REQ, ST_TX, ST_DRAIN} state_t;

    localparam logic [7:0]  SETTLE_C = 8'(SETTLE_CYCLES);
    localparam logic [7:0]  IDLE_C   = 8'(IDLE_TIMEOUT);
    localparam logic [15:0] BURST_C  = 16'(MAX_BURST);

    state_t      state_q, state_d;
    logic [7:0]  settle_q, settle_d;
    logic [7:0]  idle_q, idle_d;
    logic [15:0] burst_q, burst_d;
    logic        burst_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RX;
            settle_q <= '0;
            idle_q   <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            idle_q   <= idle_d;
            burst_q  <= burst_d;
        end
    end

    // Once the burst quota is spent and the peer waits, stop accepting so the
    // exit lands on a cycle without a write.
    assign burst_hit = (burst_q >= BURST_C) && peer_req;

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        idle_d    = idle_q;
        burst_d   = burst_q;
        tx_ready  = 1'b0;
        fifo_winc = 1'b0;
        rx_valid  = 1'b0;
        fifo_rinc = 1'b0;
        case (state_q)
            ST_RX: begin
                rx_valid  = !fifo_empty;
                fifo_rinc = rx_valid && rx_ready;
                if (tx_valid && !peer_req) begin
                    state_d  = ST_REQ;
                    settle_d = '0;
                end
            end
            ST_REQ: begin
                rx_valid  = !fifo_empty;
                fifo_rinc = rx_valid && rx_ready;
                if (settle_q != SETTLE_C)
                    settle_d = settle_q + 8'd1;
                // Yield beats grant; reaching the else means !peer_req or MASTER.
                if (peer_req && !MASTER) begin
                    state_d = ST_RX;
                end else if (settle_q == SETTLE_C && fifo_empty) begin
                    state_d = ST_TX;
                    burst_d = '0;
                    idle_d  = '0;
                end
            end
            ST_TX: begin
                tx_ready  = !fifo_full && !burst_hit;
                fifo_winc = tx_valid && tx_ready;
                if (fifo_winc && burst_q != 16'hFFFF)
                    burst_d = burst_q + 16'd1;
                if (tx_valid)
                    idle_d = '0;
                else if (idle_q != IDLE_C)
                    idle_d = idle_q + 8'd1;
                if (idle_q == IDLE_C || burst_hit)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_drained)
                    state_d = ST_RX;
            end
            default: state_d = ST_RX;
        endcase
    end

    assign fifo_dir   = (state_q == ST_TX) || (state_q == ST_DRAIN);
    assign own_req    = (state_q != ST_RX);
    assign busy_tx    = (state_q != ST_RX);
    assign rx_data    = fifo_rdata;
    assign fifo_wdata = tx_data;

`ifdef BIDIR_FIFO_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_turns    <= '0;
            stat_tx_words <= '0;
        end else begin
            if (state_q == ST_REQ && state_d == ST_TX)
                stat_turns <= stat_turns + 16'd1;
            if (fifo_winc)
                stat_tx_words <= stat_tx_words + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bidir_fifo_dir_arbiter.sv
// Scoreboard bench: written/read words queued at stimulus, checked on the FIFO strobes.
module tb_bidir_fifo_dir_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       rx_ready = 1'b0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = '0;
    logic       fifo_drained = 1'b0;
    logic       peer_req = 1'b0;

    logic       tx_ready, rx_valid, fifo_dir, fifo_winc, fifo_rinc, own_req, busy_tx;
    logic [7:0] rx_data, fifo_wdata;
    logic       m0_tx_ready, m0_rx_valid, m0_dir, m0_winc, m0_rinc, m0_own_req, m0_busy_tx;
    logic [7:0] m0_rx_data, m0_wdata;
`ifdef BIDIR_FIFO_ARB_STATS_EN
    logic [15:0] stat_turns, m0_stat_turns;
    logic [31:0] stat_tx_words, m0_stat_tx_words;
`endif

    int total = 0;
    int bad = 0;
    int winc_cnt = 0;
    logic [7:0] wq[$];
    logic [7:0] rq[$];
    logic [7:0] exp_w, exp_r;

    always #5 clk = ~clk;

    bidir_fifo_dir_arbiter #(.DSIZE(8), .MASTER(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_drained(fifo_drained), .fifo_dir(fifo_dir), .fifo_winc(fifo_winc),
        .fifo_wdata(fifo_wdata), .fifo_rinc(fifo_rinc), .own_req(own_req),
        .peer_req(peer_req),
`ifdef BIDIR_FIFO_ARB_STATS_EN
        .stat_turns(stat_turns), .stat_tx_words(stat_tx_words),
`endif
        .busy_tx(busy_tx)
    );

    bidir_fifo_dir_arbiter #(.DSIZE(8), .MASTER(1'b0)) dut_m0 (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(m0_tx_ready),
        .rx_valid(m0_rx_valid), .rx_data(m0_rx_data), .rx_ready(rx_ready),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_drained(fifo_drained), .fifo_dir(m0_dir), .fifo_winc(m0_winc),
        .fifo_wdata(m0_wdata), .fifo_rinc(m0_rinc), .own_req(m0_own_req),
        .peer_req(peer_req),
`ifdef BIDIR_FIFO_ARB_STATS_EN
        .stat_turns(m0_stat_turns), .stat_tx_words(m0_stat_tx_words),
`endif
        .busy_tx(m0_busy_tx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input int n, input int budget);
        int   sent = 0;
        int   waited = 0;
        logic acc;
        tx_data = 8'($urandom);
        wq.push_back(tx_data);
        tx_valid = 1'b1;
        while (sent < n && waited < budget) begin
            #1;
            acc = fifo_winc;
            tick();
            waited++;
            if (acc) begin
                sent++;
                if (sent < n) begin
                    tx_data = 8'($urandom);
                    wq.push_back(tx_data);
                end
            end
        end
        tx_valid = 1'b0;
        chk("send_cnt", 32'(sent), 32'(n));
    endtask

    // Scoreboard side: every strobe must carry the next queued word.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_excl", {31'd0, fifo_winc & fifo_rinc}, 32'd0);
            if (fifo_winc) begin
                winc_cnt++;
                if (wq.size() == 0) chk("wq_underflow", 32'd1, 32'd0);
                else begin
                    exp_w = wq.pop_front();
                    chk("wdata", {24'd0, fifo_wdata}, {24'd0, exp_w});
                end
            end
            if (fifo_rinc) begin
                if (rq.size() == 0) chk("rq_underflow", 32'd1, 32'd0);
                else begin
                    exp_r = rq.pop_front();
                    chk("rdata", {24'd0, rx_data}, {24'd0, exp_r});
                end
            end
        end
    end

    initial begin
        int n;
        int k;
        logic m0_dir_seen;
        logic acc;

        // reset and idle
        tick();
        tick();
        chk("rst_dir", {31'd0, fifo_dir}, 0);
        chk("rst_own", {31'd0, own_req}, 0);
        chk("rst_busy", {31'd0, busy_tx}, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_dir", {31'd0, fifo_dir}, 0);
        chk("idle_own", {31'd0, own_req}, 0);
        chk("idle_rxv", {31'd0, rx_valid}, 0);
        chk("idle_winc", {31'd0, fifo_winc}, 0);
        chk("idle_rinc", {31'd0, fifo_rinc}, 0);
        chk("idle_txr", {31'd0, tx_ready}, 0);

        // RX path
        fifo_empty = 1'b0;
        fifo_rdata = 8'hA5;
        rx_ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rq.push_back(8'hA5);
            #1;
            chk("rx_valid", {31'd0, rx_valid}, 1);
            chk("rx_rinc", {31'd0, fifo_rinc}, 1);
            tick();
        end
        rx_ready = 1'b0;
        #1;
        chk("rx_hold_rinc", {31'd0, fifo_rinc}, 0);
        chk("rx_hold_valid", {31'd0, rx_valid}, 1);
        tick();
        fifo_empty = 1'b1;
        fifo_rdata = 8'h00;
        chk("rq_empty", 32'(rq.size()), 0);

        // transmit, idle timeout, drain
        tx_valid = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!own_req && k < 10);
        chk("own_rise_lat", 32'(k), 1);
        tx_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!fifo_dir && n < 20);
        chk("grant_lat", 32'(n), 5);
        winc_cnt = 0;
        send_words(5, 40);
        chk("tx_words", 32'(winc_cnt), 5);
        repeat (8) tick();
        chk("idle8_still_tx", {31'd0, tx_ready}, 1);
        tick();
        chk("drain_txr", {31'd0, tx_ready}, 0);
        chk("drain_dir", {31'd0, fifo_dir}, 1);
        chk("drain_own", {31'd0, own_req}, 1);
        fifo_drained = 1'b1;
        tick();
        fifo_drained = 1'b0;
        chk("post_dir", {31'd0, fifo_dir}, 0);
        chk("post_own", {31'd0, own_req}, 0);
        chk("wq_empty", 32'(wq.size()), 0);

        // tie-break: peer rises on the cycle own_req rises
        tx_valid = 1'b1;
        tick();
        chk("tie_own_m1", {31'd0, own_req}, 1);
        chk("tie_own_m0", {31'd0, m0_own_req}, 1);
        peer_req = 1'b1;
        tx_valid = 1'b0;
        tick();
        chk("tie_yield_m0", {31'd0, m0_own_req}, 0);
        chk("tie_hold_m1", {31'd0, own_req}, 1);
        n = 1;
        m0_dir_seen = m0_dir;
        while (!fifo_dir && n < 20) begin
            tick();
            n++;
            m0_dir_seen = m0_dir_seen | m0_dir;
        end
        chk("tie_grant_m1", 32'(n), 5);
        chk("tie_dir_m0", {31'd0, m0_dir_seen}, 0);

        // fairness: burst cap with peer waiting, full pulse mid-burst
        winc_cnt = 0;
        tx_data  = 8'($urandom);
        wq.push_back(tx_data);
        tx_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            fifo_full = (i == 6 || i == 7);
            #1;
            if (fifo_full) begin
                chk("full_txr", {31'd0, tx_ready}, 0);
                chk("full_winc", {31'd0, fifo_winc}, 0);
            end
            acc = fifo_winc;
            tick();
            if (acc) begin
                tx_data = 8'($urandom);
                wq.push_back(tx_data);
            end
        end
        fifo_full = 1'b0;
        tx_valid  = 1'b0;
        chk("burst_words", 32'(winc_cnt), 16);
        chk("burst_pending", 32'(wq.size()), 1);
        wq.delete();
        #1;
        chk("burst_drain_txr", {31'd0, tx_ready}, 0);
        chk("burst_drain_dir", {31'd0, fifo_dir}, 1);
        chk("burst_m0_dir", {31'd0, m0_dir}, 0);
        fifo_drained = 1'b1;
        tick();
        fifo_drained = 1'b0;
        peer_req     = 1'b0;
        chk("burst_post_dir", {31'd0, fifo_dir}, 0);

        // reset mid-TX
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        n = 0;
        while (!fifo_dir && n < 20) begin tick(); n++; end
        chk("rtx_grant", {31'd0, fifo_dir}, 1);
        winc_cnt = 0;
        send_words(3, 20);
        chk("rtx_words", 32'(winc_cnt), 3);
        chk("rtx_txr", {31'd0, tx_ready}, 1);
`ifdef BIDIR_FIFO_ARB_STATS_EN
        chk("stat_turns", {16'd0, stat_turns}, 3);
        chk("stat_words", stat_tx_words, 24);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dir", {31'd0, fifo_dir}, 0);
        chk("arst_own", {31'd0, own_req}, 0);
        chk("arst_busy", {31'd0, busy_tx}, 0);
        chk("arst_txr", {31'd0, tx_ready}, 0);
        chk("arst_winc", {31'd0, fifo_winc}, 0);
        chk("arst_m0_dir", {31'd0, m0_dir}, 0);
`ifdef BIDIR_FIFO_ARB_STATS_EN
        chk("arst_turns", {16'd0, stat_turns}, 0);
        chk("arst_words", stat_tx_words, 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bidir_fifo_dir_arbiter.md
Name: bidir_fifo_dir_arbiter

Overview:
- Single-clock direction controller for one side of the bidirectional async RAM-interface FIFO.
- Owns that side's dir, winc and rinc, and presents simple streaming ports to local logic: a TX valid/ready port and an RX valid/ready port.
- Negotiates direction ownership with the peer side through a request level, which is synchronized externally.
- Turns the shared FIFO around only after it has drained, and limits TX burst length for fairness.

Parameters:
- DSIZE, 8, data width; matches the FIFO.
- MASTER, 1, tie-break priority: 1 wins a simultaneous request, 0 yields.
- SETTLE_CYCLES, 4, cycles own_req is held before granting TX; must be ≥ peer round-trip sync latency. Range 1..255.
- MAX_BURST, 16, words written before yielding when peer_req is high. Range 1..65535.
- IDLE_TIMEOUT, 8, consecutive cycles with tx_valid low before releasing TX. Range 1..255.

Ports:
- clk  in  1  block clock; the FIFO-side clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_valid  in  1  local word available to send.
- tx_data  in  DSIZE  local word.
- tx_ready  out  1  word accepted this cycle.
- rx_valid  out  1  received word available.
- rx_data  out  DSIZE  received word; first-word fall-through.
- rx_ready  in  1  local consumer accepts.
- fifo_full  in  1  FIFO full, from this side's write logic.
- fifo_empty  in  1  FIFO empty, from this side's read logic.
- fifo_rdata  in  DSIZE  FIFO read data.
- fifo_drained  in  1  every word written by this side has been consumed by the peer.
- fifo_dir  out  1  1 = this side writes; 0 = this side reads.
- fifo_winc  out  1  FIFO write strobe.
- fifo_wdata  out  DSIZE  FIFO write data; equals tx_data.
- fifo_rinc  out  1  FIFO read strobe.
- own_req  out  1  this side holds or wants write ownership; the peer synchronizes it.
- peer_req  in  1  peer's own_req, already synchronized into clk.
- busy_tx  out  1  state ≠ RX.

Behaviour:
- Reset values: state = RX, fifo_dir = 0, own_req = 0, busy_tx = 0, all counters = 0.
- In RX, fifo_winc = 0 and tx_ready = 0.
- rx_valid, fifo_rinc and rx_data are combinational from state, fifo_empty, rx_ready and fifo_rdata, as defined under RX below.
- States: RX, REQ, TX, DRAIN. fifo_dir = 1 in TX and DRAIN only.
- RX:
  - rx_valid = !fifo_empty.
  - fifo_rinc = rx_valid & rx_ready.
  - rx_data = fifo_rdata.
  - If tx_valid & !peer_req: go to REQ, set own_req = 1, clear the settle counter.
- REQ:
  - RX read path stays active and fifo_dir stays 0.
  - Settle counter increments each cycle, saturating at SETTLE_CYCLES.
  - If peer_req & !MASTER: own_req = 0, return to RX. The yield takes priority over the grant.
  - If settle == SETTLE_CYCLES & fifo_empty & (!peer_req | MASTER): go to TX. fifo_dir = 1 from the next cycle.
  - If tx_valid drops before grant: remain in REQ; the request is not withdrawn.
- TX:
  - tx_ready = !fifo_full.
  - fifo_winc = tx_valid & tx_ready.
  - rx_valid = 0 and fifo_rinc = 0.
  - Burst counter increments on each fifo_winc; cleared on TX entry.
  - Idle counter increments while !tx_valid and clears on tx_valid.
  - Exit to DRAIN when idle == IDLE_TIMEOUT, or when (burst ≥ MAX_BURST & peer_req) at a cycle with no fifo_winc.
  - fifo_full alone never forces an exit.
- DRAIN:
  - fifo_dir = 1, no strobes, own_req held.
  - When fifo_drained: own_req = 0, go to RX. fifo_dir = 0 from the next cycle.
- fifo_winc and fifo_rinc are never both 1. fifo_dir changes only on a REQ→TX or DRAIN→RX transition.
- Reset asserted mid-TX or mid-DRAIN: immediate return to reset values. Any words in flight are the FIFO's concern.

Optional Feature:
- BIDIR_FIFO_ARB_STATS_EN defined:
  - Adds output stat_turns (16 bits): count of REQ→TX transitions, wraps.
  - Adds output stat_tx_words (32 bits): count of fifo_winc pulses, wraps.
  - Both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle with fifo_empty = 1 → fifo_dir = 0, own_req = 0, rx_valid = 0, no strobes.
- RX path: fifo_empty = 0, fifo_rdata = 0xA5, rx_ready = 1 for 3 cycles → fifo_rinc = 1 on each cycle, rx_data = 0xA5; with rx_ready = 0, fifo_rinc = 0.
- Transmit: tx_valid = 1, peer_req = 0, fifo_empty = 1 → own_req rises, fifo_dir = 1 exactly SETTLE_CYCLES+1 cycles later. 5 words written; then tx_valid = 0 for 8 cycles → DRAIN. fifo_drained = 1 → fifo_dir = 0, own_req = 0.
- Tie-break: MASTER = 0, peer_req rises on the same cycle own_req rises → own_req drops within the settle window, fifo_dir stays 0. Repeat with MASTER = 1 → TX is granted.
- Fairness: MAX_BURST = 16, tx_valid held high, peer_req = 1 → exactly 16 fifo_winc pulses, then DRAIN. fifo_full pulsed mid-burst → tx_ready = 0 and the write is not lost.
- Reset asserted in TX after 3 words → all outputs return to reset values asynchronously. With BIDIR_FIFO_ARB_STATS_EN defined: stat_turns = 0 and stat_tx_words = 0.
